// File: rtl/matmul_pkg.sv
// Shared defaults and FSM state encoding for the matmul input-side blocks.
package matmul_pkg;

  localparam int ARRAY_SIZE_DEF = 128;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/feed_skid_fifo.sv
// Two-entry FIFO that absorbs memory read returns so the feed stream can stall
// without losing rows. The head entry is held until it is popped.
module feed_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/input_mem_ctrl.sv
// Input memory controller: loads N rows into a memory over port A, then
// streams them back out of port B through a skid buffer onto the feed stream.
//
// Handshakes: a beat transfers on a cycle where valid && ready are both 1.
// The producer holds valid and data stable until the transfer; ready may
// change freely. Same rule for the load stream (wr_*) and feed stream (feed_*).
module input_mem_ctrl
  import matmul_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [ADDR_WIDTH-1:0]            cfg_rows,
  output logic                             busy,
  output logic                             done,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data,
  output logic                             feed_valid,
  input  logic                             feed_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] feed_data,
  output logic                             feed_last,
  output logic                             mem_en_a,
  output logic                             mem_we_a,
  output logic [ADDR_WIDTH-1:0]            mem_addr_a,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_din_a,
  output logic                             mem_en_b,
  output logic                             mem_we_b,
  output logic [ADDR_WIDTH-1:0]            mem_addr_b,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_dout_b,
  output ctrl_state_e                      dbg_state
);

  localparam int W     = ARRAY_SIZE * DATA_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_last_q, rd_last_d;

  logic          wr_fire;
  logic          rd_issue;
  logic          pop;
  logic          flush;
  logic [1:0]    skid_count;
  logic [1:0]    occ_after;
  logic [W:0]    skid_head;
  logic          head_last;

  // Skid entries carry the row data plus a flag marking row N-1.
  feed_skid_fifo #(
    .WIDTH(W + 1)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (rd_pend_q),
    .din_i   ({rd_last_q, mem_dout_b}),
    .pop_i   (pop),
    .dout_o  (skid_head),
    .count_o (skid_count)
  );

  assign head_last  = skid_head[W];
  assign feed_valid = (skid_count != 2'd0);
  assign feed_data  = skid_head[W-1:0];
  assign feed_last  = feed_valid && head_last;
  assign pop        = feed_valid && feed_ready;
  assign flush      = abort && (state_q != ST_IDLE);

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign wr_ready  = (state_q == ST_LOAD);
  assign wr_fire   = wr_ready && wr_valid;

  // A slot freed by this cycle's pop counts as available, so a steady
  // feed_ready=1 sustains one issued read per cycle without exceeding 2.
  assign occ_after = skid_count + {1'b0, rd_pend_q} - {1'b0, pop};
  assign rd_issue  = (state_q == ST_FEED) && !abort && (occ_after < 2'd2);

  assign done = (state_q == ST_DRAIN) && pop && head_last && !abort;

  assign mem_en_a   = wr_fire;
  assign mem_we_a   = wr_fire;
  assign mem_addr_a = wr_fire ? wr_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign mem_din_a  = wr_fire ? wr_data : '0;

  assign mem_en_b   = rd_issue;
  assign mem_we_b   = 1'b0;
  assign mem_addr_b = rd_issue ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;

  // State, row count, counters and the one-deep read-return tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
    end
  end

  // Next-state logic: counters advance on accepted writes / issued reads;
  // abort from any active state returns to IDLE and drops the in-flight read.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rd_pend_d = rd_issue;
    rd_last_d = rd_issue && (rd_cnt_q == n_q - CW'(1));
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          n_d      = (cfg_rows == '0) ? CW'(DEPTH) : {1'b0, cfg_rows};
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wr_fire) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q == n_q - CW'(1)) state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == n_q - CW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      rd_pend_d = 1'b0;
      rd_last_d = 1'b0;
    end
  end

endmodule
